// File: rtl/opcodes_pkg.sv
// Shared ALU/writeback definitions.
// Flag bit indices and branch condition encoding.
`ifndef OPCODES_FLAGS_SVH
`define OPCODES_FLAGS_SVH
`define FLAGS_Z 0
`define FLAGS_N 1
`define FLAGS_C 2
`define FLAGS_V 3
`endif

package opcodes;

  localparam int FLAGS_W = 4;
  localparam int DATA_W  = 16;

  typedef enum logic [2:0] {
    AL = 3'd0,
    EQ = 3'd1,
    NE = 3'd2,
    CS = 3'd3,
    CC = 3'd4,
    MI = 3'd5,
    PL = 3'd6,
    LT = 3'd7
  } cond_t;

endpackage

// File: rtl/wb_skid_buffer.sv
// Small circular buffer between the ALU result
// and the register-file write port.
module wb_skid_buffer #(
  parameter int W     = 20,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;

  always_comb begin
    cnt_n = cnt;
    unique case ({push, pop})
      2'b10:   cnt_n = cnt + CW'(1);
      2'b01:   cnt_n = cnt - CW'(1);
      default: cnt_n = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      ready <= 1'b1;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      ready <= 1'b1;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= wp + PW'(1);
      end
      if (pop)
        rp <= rp + PW'(1);
      cnt   <= cnt_n;
      ready <= (cnt_n < FULL);
    end
  end

  assign dout  = mem[rp];
  assign valid = (cnt != '0);

endmodule

// File: rtl/alu_writeback.sv
// Execute-to-writeback stage: status register,
// branch condition evaluation and result buffering.
module alu_writeback
  import opcodes::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 3
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic          InValid,
  output logic          InReady,
  input  logic [15:0]   InResult,
  input  logic [3:0]    InFlags,
  input  logic [AW-1:0] InDest,
  input  logic          InWrEn,
  input  logic          InSetFlags,
  input  logic          Flush,
  output logic          WbValid,
  input  logic          WbReady,
  output logic [15:0]   WbData,
  output logic [AW-1:0] WbAddr,
  output logic          WbWe,
  output logic [3:0]    Status,
  output logic          CarryIn,
  input  logic [2:0]    CondSel,
  output logic          CondTrue
);

  localparam int PW = DATA_W + AW + 1;

  logic          accept;
  logic          pop;
  logic [PW-1:0] head;

  assign accept = InValid && InReady && !Flush && nReset;
  assign pop    = WbValid && WbReady && !Flush;

  wb_skid_buffer #(
    .W     (PW),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (Clock),
    .rst_n (nReset),
    .flush (Flush),
    .push  (accept),
    .pop   (pop),
    .din   ({InResult, InDest, InWrEn}),
    .dout  (head),
    .valid (WbValid),
    .ready (InReady)
  );

  assign {WbData, WbAddr, WbWe} = head;

  // Flags track the youngest accepted beat, not the writeback order.
  always_ff @(posedge Clock) begin
    if (!nReset)
      Status <= '0;
    else if (accept && InSetFlags)
      Status <= InFlags;
  end

  assign CarryIn = Status[`FLAGS_C];

  always_comb begin
    CondTrue = 1'b1;
    unique case (cond_t'(CondSel))
      AL: CondTrue = 1'b1;
      EQ: CondTrue = Status[`FLAGS_Z];
      NE: CondTrue = !Status[`FLAGS_Z];
      CS: CondTrue = Status[`FLAGS_C];
      CC: CondTrue = !Status[`FLAGS_C];
      MI: CondTrue = Status[`FLAGS_N];
      PL: CondTrue = !Status[`FLAGS_N];
      LT: CondTrue = Status[`FLAGS_N] ^ Status[`FLAGS_V];
    endcase
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: vector table
// plus hand-written multi-cycle sequences.
module tb_alu_writeback;

  logic        Clock;
  logic        nReset;
  logic        InValid;
  logic        InReady;
  logic [15:0] InResult;
  logic [3:0]  InFlags;
  logic [2:0]  InDest;
  logic        InWrEn;
  logic        InSetFlags;
  logic        Flush;
  logic        WbValid;
  logic        WbReady;
  logic [15:0] WbData;
  logic [2:0]  WbAddr;
  logic        WbWe;
  logic [3:0]  Status;
  logic        CarryIn;
  logic [2:0]  CondSel;
  logic        CondTrue;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] wlog[$];

  alu_writeback #(.DEPTH(2), .AW(3)) dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .InValid    (InValid),
    .InReady    (InReady),
    .InResult   (InResult),
    .InFlags    (InFlags),
    .InDest     (InDest),
    .InWrEn     (InWrEn),
    .InSetFlags (InSetFlags),
    .Flush      (Flush),
    .WbValid    (WbValid),
    .WbReady    (WbReady),
    .WbData     (WbData),
    .WbAddr     (WbAddr),
    .WbWe       (WbWe),
    .Status     (Status),
    .CarryIn    (CarryIn),
    .CondSel    (CondSel),
    .CondTrue   (CondTrue)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock)
    if (nReset && WbValid && WbReady && !Flush)
      wlog.push_back(WbData);

  typedef struct {
    logic        v;
    logic [15:0] res;
    logic [3:0]  flg;
    logic [2:0]  dst;
    logic        we;
    logic        sf;
    logic        fl;
    logic        rdy;
    logic [2:0]  cs;
    logic        e_ir;
    logic        e_wv;
    logic [15:0] e_wd;
    logic [2:0]  e_wa;
    logic        e_we;
    logic [3:0]  e_st;
    logic        e_ct;
  } vec_t;

  vec_t vt[11];

  function automatic vec_t mk(
    logic v, logic [15:0] res, logic [3:0] flg,
    logic [2:0] dst, logic we, logic sf, logic fl,
    logic rdy, logic [2:0] cs,
    logic e_ir, logic e_wv, logic [15:0] e_wd,
    logic [2:0] e_wa, logic e_we, logic [3:0] e_st,
    logic e_ct);
    vec_t r;
    r.v = v; r.res = res; r.flg = flg; r.dst = dst;
    r.we = we; r.sf = sf; r.fl = fl; r.rdy = rdy;
    r.cs = cs; r.e_ir = e_ir; r.e_wv = e_wv;
    r.e_wd = e_wd; r.e_wa = e_wa; r.e_we = e_we;
    r.e_st = e_st; r.e_ct = e_ct;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic beat(logic v, logic [15:0] res,
                      logic [3:0] flg, logic [2:0] dst,
                      logic we, logic sf);
    InValid    = v;
    InResult   = res;
    InFlags    = flg;
    InDest     = dst;
    InWrEn     = we;
    InSetFlags = sf;
  endtask

  logic [15:0] abc[3];
  logic        took;

  initial begin
    nReset = 1'b0;
    Flush = 1'b0;
    WbReady = 1'b0;
    CondSel = 3'd0;
    beat(1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b0);

    // Z=bit0 N=bit1 C=bit2 V=bit3
    // cond: AL0 EQ1 NE2 CS3 CC4 MI5 PL6 LT7
    vt[0]  = mk(1, 16'h1234, 4'b0000, 3'd3, 1, 0, 0, 1, 3'd0,
                1, 1, 16'h1234, 3'd3, 1, 4'b0000, 1);
    vt[1]  = mk(0, 16'h0000, 4'b0000, 3'd0, 0, 0, 0, 1, 3'd0,
                1, 0, 16'h0000, 3'd0, 0, 4'b0000, 1);
    vt[2]  = mk(1, 16'h0000, 4'b0001, 3'd1, 1, 1, 0, 1, 3'd1,
                1, 1, 16'h0000, 3'd1, 1, 4'b0001, 1);
    vt[3]  = mk(1, 16'h0005, 4'b0000, 3'd2, 0, 0, 0, 1, 3'd1,
                1, 1, 16'h0005, 3'd2, 0, 4'b0001, 1);
    vt[4]  = mk(1, 16'hFFFE, 4'b0100, 3'd4, 1, 1, 0, 1, 3'd3,
                1, 1, 16'hFFFE, 3'd4, 1, 4'b0100, 1);
    vt[5]  = mk(0, 16'h0000, 4'b0000, 3'd0, 0, 0, 0, 1, 3'd4,
                1, 0, 16'h0000, 3'd0, 0, 4'b0100, 0);
    vt[6]  = mk(1, 16'h8000, 4'b0010, 3'd0, 1, 1, 0, 0, 3'd7,
                1, 1, 16'h8000, 3'd0, 1, 4'b0010, 1);
    vt[7]  = mk(1, 16'h7FFF, 4'b1010, 3'd7, 1, 1, 0, 0, 3'd7,
                0, 1, 16'h8000, 3'd0, 1, 4'b1010, 0);
    vt[8]  = mk(1, 16'hDEAD, 4'b0001, 3'd5, 1, 1, 0, 0, 3'd5,
                0, 1, 16'h8000, 3'd0, 1, 4'b1010, 1);
    vt[9]  = mk(1, 16'hBEEF, 4'b0100, 3'd6, 1, 1, 1, 1, 3'd6,
                1, 0, 16'h0000, 3'd0, 0, 4'b1010, 0);
    vt[10] = mk(0, 16'h0000, 4'b0000, 3'd0, 0, 0, 0, 1, 3'd0,
                1, 0, 16'h0000, 3'd0, 0, 4'b1010, 1);

    // reset state
    step();
    step();
    chk("rst.ir", InReady, 1);
    chk("rst.wv", WbValid, 0);
    chk("rst.wd", WbData, 0);
    chk("rst.wa", WbAddr, 0);
    chk("rst.we", WbWe, 0);
    chk("rst.st", Status, 0);
    chk("rst.ci", CarryIn, 0);
    for (int c = 0; c < 8; c++) begin
      CondSel = 3'(c);
      #1;
      chk($sformatf("rst.ct%0d", c), CondTrue,
          (c == 0 || c == 2 || c == 4 || c == 6) ? 1 : 0);
    end

    nReset = 1'b1;
    wlog.delete();
    for (int i = 0; i < 11; i++) begin
      beat(vt[i].v, vt[i].res, vt[i].flg, vt[i].dst,
           vt[i].we, vt[i].sf);
      Flush   = vt[i].fl;
      WbReady = vt[i].rdy;
      CondSel = vt[i].cs;
      step();
      chk($sformatf("v%0d.ir", i), InReady, vt[i].e_ir);
      chk($sformatf("v%0d.wv", i), WbValid, vt[i].e_wv);
      chk($sformatf("v%0d.st", i), Status, vt[i].e_st);
      chk($sformatf("v%0d.ci", i), CarryIn, vt[i].e_st[2]);
      chk($sformatf("v%0d.ct", i), CondTrue, vt[i].e_ct);
      if (vt[i].e_wv) begin
        chk($sformatf("v%0d.wd", i), WbData, vt[i].e_wd);
        chk($sformatf("v%0d.wa", i), WbAddr, vt[i].e_wa);
        chk($sformatf("v%0d.we", i), WbWe, vt[i].e_we);
      end
    end
    Flush = 1'b0;

    // only the popped beats were written; flushed ones never
    chk("log.n", wlog.size(), 4);
    if (wlog.size() == 4) begin
      chk("log0", wlog[0], 16'h1234);
      chk("log1", wlog[1], 16'h0000);
      chk("log2", wlog[2], 16'h0005);
      chk("log3", wlog[3], 16'hFFFE);
    end

    // backpressure: A, B accepted, C held, then drain
    abc[0] = 16'hA0A0;
    abc[1] = 16'hB0B0;
    abc[2] = 16'hC0C0;
    wlog.delete();
    WbReady = 1'b0;
    beat(1'b1, abc[0], 4'h0, 3'd1, 1'b1, 1'b0);
    step();
    chk("abc.ir1", InReady, 1);
    beat(1'b1, abc[1], 4'h0, 3'd2, 1'b1, 1'b0);
    step();
    chk("abc.ir2", InReady, 0);
    chk("abc.hd2", WbData, abc[0]);
    beat(1'b1, abc[2], 4'h0, 3'd3, 1'b1, 1'b0);
    step();
    chk("abc.ir3", InReady, 0);
    chk("abc.hd3", WbData, abc[0]);
    WbReady = 1'b1;
    for (int k = 0; k < 20 && wlog.size() < 3; k++) begin
      took = InValid && InReady;
      step();
      if (took) InValid = 1'b0;
    end
    InValid = 1'b0;
    chk("abc.n", wlog.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < wlog.size())
        chk($sformatf("abc.ord%0d", i), wlog[i], abc[i]);
    step();
    chk("abc.empty", WbValid, 0);

    // full throughput with WbReady held high
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, 16'h3000 + 16'(i), 4'h0, 3'(i), 1'b1, 1'b0);
      step();
      chk($sformatf("tp%0d.wv", i), WbValid, 1);
      chk($sformatf("tp%0d.wd", i), WbData, 16'h3000 + 16'(i));
      chk($sformatf("tp%0d.ir", i), InReady, 1);
    end
    beat(1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b0);
    step();
    chk("tp.empty", WbValid, 0);

    // reset in the middle of a drain
    WbReady = 1'b0;
    beat(1'b1, 16'hD00D, 4'b0100, 3'd5, 1'b1, 1'b1);
    step();
    beat(1'b1, 16'hE00E, 4'b0000, 3'd6, 1'b1, 1'b0);
    step();
    chk("rmd.ir", InReady, 0);
    WbReady = 1'b1;
    beat(1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b0);
    step();
    chk("rmd.hd", WbData, 16'hE00E);
    chk("rmd.ci", CarryIn, 1);
    nReset = 1'b0;
    beat(1'b1, 16'hF00F, 4'b1111, 3'd7, 1'b1, 1'b1);
    step();
    chk("rmd.wv", WbValid, 0);
    chk("rmd.ir2", InReady, 1);
    chk("rmd.wd", WbData, 0);
    chk("rmd.wa", WbAddr, 0);
    chk("rmd.we", WbWe, 0);
    chk("rmd.st", Status, 0);
    chk("rmd.ci2", CarryIn, 0);
    nReset = 1'b1;
    beat(1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b0);
    step();
    chk("rmd.gone", WbValid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
